grasspopper_scheduler: RTL and testbench

//  Shares one grasspopper cipher core among NREQ requesters, using round-robin arbitration.

---
 rtl/grasspopper_pkg.sv | 5 +
 rtl/gp_rr_arbiter.sv | 27 ++
 rtl/grasspopper_scheduler.sv | 91 +++++++++
 tb/tb_grasspopper_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/grasspopper_pkg.sv
// grasspopper_pkg: shared widths and scheduler state encoding
package grasspopper_pkg;
    localparam int BLOCK_W = 128;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, DELIVER} gp_sched_state_t;
endpackage

// File: rtl/gp_rr_arbiter.sv
// gp_rr_arbiter: combinational round-robin pick of the first request after ptr
module gp_rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    int k;
    // Walk from farthest to nearest so the nearest valid requester overwrites.
    always_comb begin
        grant = '0;
        idx = '0;
        k = 0;
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (en && req[k]) begin
                grant = '0;
                grant[k] = 1'b1;
                idx = IDW'(k);
            end
        end
    end
endmodule

// File: rtl/grasspopper_scheduler.sv
// grasspopper_scheduler: round-robin sharing of one grasspopper core with a watchdog
module grasspopper_scheduler
    import grasspopper_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*BLOCK_W-1:0] req_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IDW-1:0]          rsp_id_o,
    output logic [BLOCK_W-1:0]      rsp_data_o,
    output logic                    rsp_err_o,
    output logic [BLOCK_W-1:0]      core_data_o,
    output logic                    core_request_o,
    output logic                    core_ack_o,
    output logic                    core_rst_o,
    input  logic [BLOCK_W-1:0]      core_data_i,
    input  logic                    core_valid_i,
    input  logic                    core_busy_i
);
    localparam int WDW = $clog2(TIMEOUT);
    gp_sched_state_t state;
    logic [IDW-1:0] rr_ptr, id, gidx;
    logic [BLOCK_W-1:0] blk, res;
    logic err, wd_pulse, wd_hit;
    logic [WDW-1:0] wd_cnt;
    gp_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req(req_valid_i),
        .ptr(rr_ptr),
        .en(state == IDLE && !core_busy_i && !rst),
        .grant(req_ready_o),
        .idx(gidx)
    );
    assign wd_hit = wd_cnt == WDW'(TIMEOUT - 1);
    assign wd_pulse = state == WAIT && !core_valid_i && wd_hit;
    assign core_rst_o = rst | wd_pulse;
    assign core_request_o = state == ISSUE;
    assign core_ack_o = state == ACK;
    assign core_data_o = blk;
    assign rsp_valid_o = state == DELIVER;
    assign rsp_id_o = id;
    assign rsp_data_o = res;
    assign rsp_err_o = err;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            blk <= '0;
            res <= '0;
            id <= '0;
            err <= 1'b0;
            wd_cnt <= '0;
            rr_ptr <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: if (|req_ready_o) begin
                    blk <= req_data_i[int'(gidx)*BLOCK_W +: BLOCK_W];
                    id <= gidx;
                    state <= ISSUE;
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (core_valid_i) begin
                        res <= core_data_i;
                        err <= 1'b0;
                        state <= ACK;
                    end else if (wd_hit) begin
                        res <= '0;
                        err <= 1'b1;
                        state <= DELIVER;
                    end
                end
                ACK: state <= DELIVER;
                DELIVER: if (rsp_ready_i) begin
                    rr_ptr <= id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grasspopper_scheduler.sv
// tb_grasspopper_scheduler: table-driven transactions plus reset/busy corner sequences
module tb_grasspopper_scheduler;
    localparam logic [127:0] BASE = 128'h00112233445566778899AABBCCDDEEFF;
    typedef struct {
        logic [3:0]   mask;
        int           lat;
        int           hold;
        logic [127:0] cout;
        logic [1:0]   eid;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] req_valid = '0, req_ready;
    logic [511:0] req_data;
    logic rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [1:0] rsp_id;
    logic [127:0] rsp_data, core_data_o, core_data_i = '0;
    logic core_request, core_ack, core_rst, core_valid = 1'b0, core_busy = 1'b0;
    int tests = 0, fails = 0;
    vec_t vt[10];
    always #5 clk = ~clk;
    grasspopper_scheduler #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .core_data_o(core_data_o), .core_request_o(core_request), .core_ack_o(core_ack),
        .core_rst_o(core_rst), .core_data_i(core_data_i), .core_valid_i(core_valid),
        .core_busy_i(core_busy)
    );
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic txn(input vec_t v);
        int n;
        logic [127:0] blk, exp_data;
        blk = BASE ^ {32{4'(v.eid)}};
        exp_data = v.lat < 64 ? v.cout : '0;
        req_valid = v.mask;
        rsp_ready = v.hold == 0;
        core_valid = 1'b0;
        core_data_i = ~v.cout;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("grant", 128'(req_ready), 128'(4'b1 << v.eid));
        if (req_ready == 4'b0) return;
        tick();
        #1;
        chk("issue_req", 128'(core_request), 128'(1));
        chk("issue_data", core_data_o, blk);
        chk("issue_ready", 128'(req_ready), 128'(0));
        for (int i = 0; i < 64; i++) begin
            tick();
            core_valid = i == v.lat;
            core_data_i = core_valid ? v.cout : ~v.cout;
            #1;
            chk("wd_rst", 128'(core_rst), 128'(i == 63 && v.lat > 63));
            if (i == v.lat) break;
        end
        tick();
        core_valid = 1'b0;
        core_data_i = ~v.cout;
        #1;
        if (v.lat < 64) begin
            chk("ack", 128'(core_ack), 128'(1));
            chk("ack_rsp", 128'(rsp_valid), 128'(0));
            tick();
            #1;
        end
        chk("ack_once", 128'(core_ack), 128'(0));
        chk("rst_once", 128'(core_rst), 128'(0));
        chk("rsp_valid", 128'(rsp_valid), 128'(1));
        chk("rsp_id", 128'(rsp_id), 128'(v.eid));
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", 128'(rsp_err), 128'(v.lat > 63));
        for (int h = 0; h < v.hold; h++) begin
            tick();
            #1;
            chk("hold_valid", 128'(rsp_valid), 128'(1));
            chk("hold_data", {rsp_data[125:0], rsp_id}, {exp_data[125:0], v.eid});
            chk("hold_quiet", 128'({core_request, req_ready, rsp_err}), 128'({1'b0, 4'b0, v.lat > 63}));
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("rsp_done", 128'(rsp_valid), 128'(0));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        for (int n = 0; n < 4; n++) req_data[n*128 +: 128] = BASE ^ {32{4'(n)}};
        vt[0] = '{4'hF, 0, 0, {4{32'hC0DE0000}}, 2'd0};
        vt[1] = '{4'hF, 5, 0, {4{32'hC0DE0001}}, 2'd1};
        vt[2] = '{4'hF, 1, 0, {4{32'hC0DE0002}}, 2'd2};
        vt[3] = '{4'hF, 2, 0, {4{32'hC0DE0003}}, 2'd3};
        vt[4] = '{4'hF, 3, 0, {4{32'hC0DE0004}}, 2'd0};
        vt[5] = '{4'h1, 10, 0, {4{32'hC0DE0005}}, 2'd0};
        vt[6] = '{4'hA, 4, 20, {4{32'hC0DE0006}}, 2'd1};
        vt[7] = '{4'hA, 100, 0, {4{32'hC0DE0007}}, 2'd3};
        vt[8] = '{4'hC, 2, 0, {4{32'hC0DE0008}}, 2'd2};
        vt[9] = '{4'h5, 63, 0, {4{32'hC0DE0009}}, 2'd0};
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        chk("reset_ready", 128'(req_ready), 128'(0));
        chk("reset_core_rst", 128'(core_rst), 128'(1));
        chk("reset_outs", {core_data_o, rsp_data}, '0);
        chk("reset_flags", 128'({rsp_valid, rsp_id, rsp_err, core_request, core_ack}), 128'(0));
        rst = 1'b0;
        core_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("busy_block", 128'({req_ready, core_request, core_rst}), 128'(0));
        end
        core_busy = 1'b0;
        foreach (vt[i]) txn(vt[i]);
        req_valid = 4'h4;
        #1;
        chk("pre_rst_grant", 128'(req_ready), 128'(4'h4));
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        #1;
        chk("midrst_ready", 128'(req_ready), 128'(0));
        chk("midrst_core_rst", 128'(core_rst), 128'(1));
        chk("midrst_flags", 128'({rsp_valid, rsp_id, rsp_err, core_request, core_ack}), 128'(0));
        chk("midrst_data", core_data_o, '0);
        rst = 1'b0;
        req_valid = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("post_rst_quiet", 128'({rsp_valid, core_rst, core_request}), 128'(0));
        end
        txn('{4'hF, 2, 0, {4{32'hC0DE000A}}, 2'd0});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
